// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one external full-adder cell.
// Adds two WIDTH-bit operands LSB first, one bit per clock, then pulses done.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, honoured only in IDLE
//   op_a, op_b, cin   operands and carry-in, captured when start is accepted
//   busy              high while bits are being processed
//   done              one-cycle completion pulse
//   sum, cout         registered result, held until the next completion
//   fa_a, fa_b, fa_c  full-adder inputs (decode of registers, 0 outside RUN)
//   fa_sum, fa_carry  full-adder outputs
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic             load_c;
  logic             last_c;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nx_c;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Result shift register input: new sum bit enters at the MSB end.
  generate
    if (WIDTH == 1) begin : g_r_one
      assign r_nx_c = fa_sum;
    end else begin : g_r_many
      assign r_nx_c = {fa_sum, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state decode; DONE always falls back to IDLE after one cycle.
  always_comb begin
    state_nx = state_q;
    load_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          last_c   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand/result shifters, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (load_c) begin
      a_sh    <= op_a;
      b_sh    <= op_b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      r_sh    <= r_nx_c;
      carry_q <= fa_carry;
      cnt_q   <= cnt_q + CW'(1);
      if (last_c) begin
        sum_q  <= r_nx_c;
        cout_q <= fa_carry;
      end
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == RUN);
      done_q <= (state_nx == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

  // Adder inputs are gated by RUN so the cell sees zeros when idle.
  assign fa_a = (state_q == RUN) & a_sh[0];
  assign fa_b = (state_q == RUN) & b_sh[0];
  assign fa_c = (state_q == RUN) & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=8 instance
  logic       rst8;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       fa8_a, fa8_b, fa8_c, fa8_s, fa8_co;

  // WIDTH=1 instance
  logic       rst1;
  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic       fa1_a, fa1_b, fa1_c, fa1_s, fa1_co;

  // Behavioural full-adder cells
  assign fa8_s  = fa8_a ^ fa8_b ^ fa8_c;
  assign fa8_co = (fa8_a & fa8_b) | (fa8_c & (fa8_a ^ fa8_b));
  assign fa1_s  = fa1_a ^ fa1_b ^ fa1_c;
  assign fa1_co = (fa1_a & fa1_b) | (fa1_c & (fa1_a ^ fa1_b));

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_c(fa8_c), .fa_sum(fa8_s), .fa_carry(fa8_co)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst1), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_c(fa1_c), .fa_sum(fa1_s), .fa_carry(fa1_co)
  );

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  task automatic test_reset();
    rst8 = 1'b0; rst1 = 1'b0;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy8, done8, sum8, cout8, fa8_a, fa8_b, fa8_c} !== 14'h0) begin
        n_err++;
        $display("FAIL reset8 cyc=%0d got busy=%b done=%b sum=%h cout=%b fa=%b%b%b want all 0",
                 cyc, busy8, done8, sum8, cout8, fa8_a, fa8_b, fa8_c);
      end
      n_cmp++;
      if ({busy1, done1, sum1, cout1, fa1_a, fa1_b, fa1_c} !== 7'h0) begin
        n_err++;
        $display("FAIL reset1 got busy=%b done=%b sum=%b cout=%b want all 0", busy1, done1, sum1, cout1);
      end
    end
    start8 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    rst8 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
  endtask

  // One WIDTH=8 addition with per-bit checks of the adder drive.
  // Entered and left at a negedge with the DUT idle. inject: pulse start mid-RUN.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit inject, input string tag);
    logic       carry;
    logic [8:0] exp_v;
    logic [8:0] got;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = ~a; b8 = 8'h5C; cin8 = ~c;
    carry = c;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inject && i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end
      if (inject && i == 4) start8 = 1'b0;
      n_cmp++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy bit%0d got busy=%b done=%b want 1/0", tag, i, busy8, done8);
      end
      n_cmp++;
      if ({fa8_a, fa8_b, fa8_c} !== {a[i], b[i], carry}) begin
        n_err++;
        $display("FAIL %s fa bit%0d got a,b,c=%b%b%b want %b%b%b", tag, i,
                 fa8_a, fa8_b, fa8_c, a[i], b[i], carry);
      end
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    @(negedge clk);
    n_cmp++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || {fa8_a, fa8_b, fa8_c} !== 3'b000) begin
      n_err++;
      $display("FAIL %s done cycle got done=%b busy=%b fa=%b%b%b want done=1 busy=0 fa=000",
               tag, done8, busy8, fa8_a, fa8_b, fa8_c);
    end
    if (done8 === 1'b1 && q8.size() > 0) begin
      exp_v = q8.pop_front();
      got = {cout8, sum8};
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL %s result got cout,sum=%h want %h", tag, got, exp_v);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL %s after done got done=%b busy=%b want 0/0", tag, done8, busy8);
    end
  endtask

  task automatic test_zero();
    run_op8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_carry_chain();
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0, "ripple");
  endtask

  task automatic test_patterns();
    run_op8(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a");
    run_op8(8'h3C, 8'h0F, 1'b0, 1'b0, "3c_0f");
  endtask

  task automatic test_midrun_start();
    run_op8(8'h11, 8'h22, 1'b0, 1'b1, "midrun");
    // A stray retrigger would show up as busy here.
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL midrun retrigger got busy=%b want 0", busy8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    int         t_done[3];
    int         seen;
    logic [8:0] exp_v;
    ta[0] = 8'h10; tb[0] = 8'h20;
    ta[1] = 8'hF0; tb[1] = 8'h33;
    ta[2] = 8'h81; tb[2] = 8'h7F;
    seen = 0;
    start8 = 1'b1; a8 = ta[0]; b8 = tb[0]; cin8 = 1'b0;
    q8.push_back(9'(ta[0]) + 9'(tb[0]));
    for (int n = 0; n < 40 && seen < 3; n++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        t_done[seen] = cyc;
        exp_v = q8.pop_front();
        n_cmp++;
        if ({cout8, sum8} !== exp_v) begin
          n_err++;
          $display("FAIL b2b result%0d got %h want %h", seen, {cout8, sum8}, exp_v);
        end
        seen++;
        if (seen < 3) begin
          a8 = ta[seen]; b8 = tb[seen];
          q8.push_back(9'(ta[seen]) + 9'(tb[seen]));
        end else begin
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    n_cmp++;
    if (seen != 3) begin
      n_err++;
      $display("FAIL b2b timeout got %0d done pulses want 3", seen);
    end else begin
      for (int j = 1; j < 3; j++) begin
        n_cmp++;
        if (t_done[j] - t_done[j-1] != 10) begin
          n_err++;
          $display("FAIL b2b spacing%0d got %0d cycles want 10", j, t_done[j] - t_done[j-1]);
        end
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL b2b drain got busy=%b queued=%0d want 0/0", busy8, q8.size());
    end
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst8 = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8, fa8_a, fa8_b, fa8_c} !== 14'h0) begin
      n_err++;
      $display("FAIL rst_midrun got busy=%b done=%b sum=%h cout=%b fa=%b%b%b want all 0",
               busy8, done8, sum8, cout8, fa8_a, fa8_b, fa8_c);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0) saw_done = 1'b1;
    end
    rst8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL rst_midrun activity after abort got done/busy seen=1 want 0");
    end
    run_op8(8'h12, 8'h34, 1'b0, 1'b0, "post_rst");
  endtask

  task automatic test_width1();
    logic [1:0] exp_v;
    logic       ea, eb, ec;
    for (int v = 0; v < 8; v++) begin
      ea = v[2]; eb = v[1]; ec = v[0];
      start1 = 1'b1; a1 = ea; b1 = eb; cin1 = ec;
      q1.push_back({(ea & eb) | (ec & (ea | eb)), ea ^ eb ^ ec});
      @(posedge clk);
      #1;
      start1 = 1'b0; a1 = ~ea; b1 = ~eb; cin1 = ~ec;
      @(negedge clk);
      n_cmp++;
      if (busy1 !== 1'b1 || {fa1_a, fa1_b, fa1_c} !== {ea, eb, ec}) begin
        n_err++;
        $display("FAIL w1 run%0d got busy=%b fa=%b%b%b want 1 %b%b%b", v,
                 busy1, fa1_a, fa1_b, fa1_c, ea, eb, ec);
      end
      @(negedge clk);
      n_cmp++;
      if (done1 !== 1'b1 || busy1 !== 1'b0) begin
        n_err++;
        $display("FAIL w1 done%0d got done=%b busy=%b want 1/0", v, done1, busy1);
      end
      exp_v = q1.pop_front();
      n_cmp++;
      if ({cout1, sum1} !== exp_v) begin
        n_err++;
        $display("FAIL w1 result%0d got cout,sum=%b want %b", v, {cout1, sum1}, exp_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry_chain();
    test_patterns();
    test_midrun_start();
    test_back_to_back();
    test_reset_midrun();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences one external single-bit full adder (inputs a, b, c; outputs sum, carry) to add two WIDTH-bit operands, LSB first, one bit per clock. It latches operands on a start request, drives the adder's inputs from internal shift registers, and feeds the adder's carry back through a carry flop. It assembles the result and reports completion with a one-cycle done pulse. It sits between a requesting host and the full-adder datapath, trading WIDTH cycles of latency for a single adder cell.

## Interface

- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  first operand, sampled with accepted start
- op_b  input  WIDTH  second operand, sampled with accepted start
- cin  input  1  carry-in, sampled with accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held until next completion
- fa_a  output  1  to full adder a
- fa_b  output  1  to full adder b
- fa_c  output  1  to full adder c (carry-in)
- fa_sum  input  1  from full adder sum (combinational)
- fa_carry  input  1  from full adder carry (combinational)

## Operation

- Reset (rst_n low, asynchronous): state IDLE; busy, done, sum, cout, fa_a, fa_b, fa_c all 0; shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge loads a_sh<=op_a, b_sh<=op_b, carry_q<=cin, cnt<=0, then RUN. start=0 stays IDLE.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_q (combinational from registers). Each edge: a_sh, b_sh shift right one; r_sh shifts right with fa_sum entering at bit WIDTH-1; carry_q<=fa_carry; cnt<=cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1, sum<={fa_sum, r_sh[WIDTH-1:1]}, cout<=fa_carry, then DONE.
- DONE: exactly one cycle, then IDLE unconditionally.
- fa_a, fa_b, fa_c are 0 outside RUN.
- start is ignored in RUN and DONE; there is no queueing. A start held high re-triggers on the first IDLE edge.
- op_a, op_b, cin changes after acceptance do not affect the operation in progress.
- Arithmetic: {cout, sum} = op_a + op_b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH+1) bits. WIDTH=1 gives a single RUN cycle.
- Reset asserted mid-operation aborts immediately to the reset values. The previous sum and cout are lost, and no done pulse is produced.

## Timing

- start accepted at edge k: busy=1 from after edge k through edge k+WIDTH.
- Bit i is presented on fa_* during cycle k+i+1, for i = 0..WIDTH-1.
- sum and cout update at edge k+WIDTH. done=1 for the single cycle between edges k+WIDTH and k+WIDTH+1, and busy=0 in that cycle.
- The earliest next acceptance is edge k+WIDTH+2. Throughput is one addition per WIDTH+2 cycles.
- All outputs except fa_* are registered. fa_* are a decode of registers only, with no input-to-output combinational path.

## Test plan

- WIDTH=8, reset then start with 0x00+0x00, cin=0 -> done after 8 busy cycles; sum=0x00, cout=0. Check every output is 0 during reset.
- WIDTH=8, 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Check the carry chain ripples through all bits via fa_c.
- WIDTH=8, 0xA5+0x5A, cin=1 -> sum=0x00, cout=1. Also 0x3C+0x0F, cin=0 -> sum=0x4B, cout=0. Check the fa_a/fa_b bit sequence is LSB first.
- WIDTH=8, start pulsed again mid-RUN with different operands -> ignored; the original result completes. Start held high continuously -> back-to-back operations spaced exactly 10 cycles apart.
- WIDTH=8, rst_n dropped at the 4th RUN cycle -> busy, sum, cout and fa_* go to 0 immediately with no done. A fresh 0x12+0x34 afterwards -> 0x46, cout=0.
- WIDTH=1, all 8 combinations of op_a, op_b, cin -> {cout, sum} matches the full-adder truth table (sum = a^b^c, cout = majority); done after 1 busy cycle.
